mem_stage: RTL
==============

# mem_stage

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It turns the registered access request into a transaction on the SRAM-like data port, using a req/addr_ok/data_ok handshake. It stalls the pipeline via MEM_stall until the access completes. It delivers an aligned, sign- or zero-extended load result to the MEM/WB register.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- MEM_in_data_sram_en  in  1  instruction in MEM performs a memory access
- MEM_in_data_sram_addr  in  32  byte address
- MEM_in_data_sram_wdata  in  32  store data (unaligned, low-justified)
- MEM_mem_type  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- MEM_exc  in  1  OR of all exception flags carried by the instruction in MEM
- MEM_flush  in  1  pipeline flush (exception/eret taken this cycle)
- data_req  out  1  request valid
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  response (read data or write ack) this cycle
- data_rdata  in  32  read data, valid with data_data_ok
- MEM_stall  out  1  hold EX/MEM and everything upstream
- MEM_out_load_data  out  32  extended load result
- MEM_out_load_valid  out  1  MEM_out_load_data valid this cycle

## Operation
- pending = MEM_in_data_sram_en & ~MEM_exc & ~MEM_flush.
- States: IDLE, REQ, WAIT, DONE, DRAIN; reset state IDLE.
- IDLE:
  - data_req = pending.
  - If pending & data_addr_ok -> WAIT.
  - If pending & ~data_addr_ok -> REQ.
  - Otherwise stay in IDLE.
- REQ:
  - data_req = 1 unconditionally; a flush must not drop the request.
  - On data_addr_ok -> WAIT (or DRAIN if flushed since issue).
- WAIT:
  - On data_data_ok -> DONE, latching data_rdata into rdata_q.
  - If flushed since issue, data_data_ok -> IDLE instead.
- DRAIN: behaves as WAIT; data_data_ok -> IDLE with the response discarded.
- DONE:
  - Lasts exactly one cycle, then -> IDLE.
  - Never issues a request, so the held instruction is not re-issued.
- Flush tracking:
  - A kill flag sets when MEM_flush occurs in REQ or WAIT.
  - It clears on returning to IDLE.
  - REQ with kill set goes to DRAIN on addr_ok; WAIT with kill set goes to IDLE on data_ok.
- MEM_stall:
  - IDLE: equals pending.
  - REQ, WAIT, DRAIN: 1.
  - DONE: 0.
- Request fields:
  - data_addr = MEM_in_data_sram_addr, full address with low bits unmodified.
  - data_size from type: byte for LB/LBU/SB, half for LH/LHU/SH, word for LW/SW.
  - data_wr = mem_type[2] & (mem_type != 100).
  - data_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Request fields are held stable while data_req is high; EX/MEM is stalled, so its inputs are stable.
- Load extraction in DONE from rdata_q:
  - Byte lane selected by addr[1:0].
  - Half lane selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- MEM_out_load_valid = (state==DONE) & ~data_wr.
- Outside DONE, MEM_out_load_data = 0.
- Misalignment is not checked here; it arrives as MEM_exc and suppresses issue.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, kill flag 0, rdata_q 0.
  - data_req 0, MEM_stall 0, MEM_out_load_valid 0, MEM_out_load_data 0.
- Reset mid-transaction abandons it; an in-flight data_data_ok after reset release is ignored in IDLE.
- Minimum access is 3 cycles:
  - Cycle 0: IDLE, req with addr_ok.
  - Cycle 1: WAIT, data_ok.
  - Cycle 2: DONE, stall low.
- EX/MEM loads the next instruction on the edge ending DONE.
- data_addr_ok and data_data_ok are never accepted in the same cycle for one transaction; data_data_ok in IDLE/REQ/DONE is ignored.
- Non-memory instructions: MEM_stall = 0, zero added latency.
- MEM_flush arriving in IDLE with pending: no request issued, since pending is gated combinationally.

## Test plan
- LW at 0x1000, addr_ok in the first cycle, data_ok 1 cycle later with 0xDEADBEEF -> MEM_stall high 2 cycles; DONE gives load_valid=1, load_data=0xDEADBEEF.
- LB at addr 0x1003 with rdata 0x80FF1234 -> load_data 0xFFFFFF80; LBU same access -> 0x00000080; LH at 0x1002 -> 0xFFFF80FF.
- SB at 0x2001 with wdata 0x000000AB, addr_ok held low 3 cycles -> data_req stays 1 with fixed fields (wr=1, size=0, wdata=0xABABABAB) for 4 cycles; load_valid never asserts.
- MEM_flush while in WAIT -> data_req stays low; MEM_stall high until data_ok; then IDLE with load_valid=0 and no re-issue.
- MEM_exc=1 with sram_en=1 -> data_req 0, MEM_stall 0, same cycle.
- rst low while in WAIT -> outputs zero immediately; a later data_ok is ignored and the next LW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM-stage controller driving an SRAM-like req/addr_ok/data_ok data port,
// stalling the pipeline until each access completes and extending load results.
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_in_data_sram_en,
  input  logic [31:0] MEM_in_data_sram_addr,
  input  logic [31:0] MEM_in_data_sram_wdata,
  input  logic [2:0]  MEM_mem_type,
  input  logic        MEM_exc,
  input  logic        MEM_flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        MEM_stall,
  output logic [31:0] MEM_out_load_data,
  output logic        MEM_out_load_valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] rdata_q, rdata_d;

  logic        pending;
  logic        kill_now;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign pending  = MEM_in_data_sram_en & ~MEM_exc & ~MEM_flush;
  // A flush in the same cycle as the handshake counts as "flushed since issue".
  assign kill_now = kill_q | MEM_flush;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (pending) state_d = data_addr_ok ? WAIT : REQ;
      end
      REQ: begin
        kill_d = kill_now;
        if (data_addr_ok) state_d = kill_now ? DRAIN : WAIT;
      end
      WAIT: begin
        kill_d = kill_now;
        if (data_data_ok) begin
          if (kill_now) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = DONE;
            rdata_d = data_rdata;
          end
        end
      end
      DRAIN: begin
        if (data_data_ok) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake outputs are forced low while reset is held, even with a live request upstream.
  assign data_req  = rst & (((state_q == IDLE) & pending) | (state_q == REQ));
  assign MEM_stall = rst & ((state_q == IDLE) ? pending : (state_q != DONE));

  assign data_addr = MEM_in_data_sram_addr;
  assign data_wr   = MEM_mem_type[2] & (MEM_mem_type != 3'b100);

  always_comb begin
    case (MEM_mem_type)
      3'b000, 3'b001, 3'b101: data_size = 2'd0;
      3'b010, 3'b011, 3'b110: data_size = 2'd1;
      default:                data_size = 2'd2;
    endcase
  end

  always_comb begin
    case (MEM_mem_type)
      3'b101:  data_wdata = {4{MEM_in_data_sram_wdata[7:0]}};
      3'b110:  data_wdata = {2{MEM_in_data_sram_wdata[15:0]}};
      default: data_wdata = MEM_in_data_sram_wdata;
    endcase
  end

  always_comb begin
    case (MEM_in_data_sram_addr[1:0])
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    half_lane = MEM_in_data_sram_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    case (MEM_mem_type)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {24'd0, byte_lane};
      3'b010:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b011:  load_ext = {16'd0, half_lane};
      default: load_ext = rdata_q;
    endcase
  end

  assign MEM_out_load_data  = (state_q == DONE) ? load_ext : 32'd0;
  assign MEM_out_load_valid = (state_q == DONE) & ~data_wr;

endmodule

`default_nettype wire
